// File: rtl/regfile_wr_demux.sv
// regfile_wr_demux
//   Write side of the 32-entry register file. Writeback requests arrive over
//   a valid/ready handshake and are buffered in a small FIFO. Each buffered
//   request is issued as a registered one-hot write enable plus registered
//   data. Writes to the hard-wired zero register are accepted and dropped.
//
// Parameters:
//   DATA_WIDTH  width of a register value
//   DEPTH       write-buffer entries (power of two, >= 2)
//   ZERO_REG    hard-wired zero register index; writes to it never issue
//
// Ports:
//   clk       clock, all state on rising edge
//   reset     synchronous, active-high
//   in_valid  write request present
//   in_ready  buffer can accept this cycle (registered count < DEPTH)
//   in_addr   destination register
//   in_data   write value
//   rf_stall  register file cannot take a new write at the coming edge
//   we        registered one-hot write enable, at most one bit set
//   wr_data   registered write value, valid when we != 0
//   busy      buffer non-empty or we != 0
//
// Optional feature (macro REGWR_FWD_EN):
//   fwd_addr  lookup address
//   fwd_hit   a pending or currently issued write targets fwd_addr
//   fwd_data  youngest matching value (0 on miss)

module regfile_wr_demux #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rf_stall,
  output logic [31:0]           we,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
`ifdef REGWR_FWD_EN
  ,
  input  logic [4:0]            fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [4:0]  ZERO_ADDR = 5'(ZERO_REG);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [31:0]           we_q, we_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [4:0]            addr_mem_q [DEPTH];
  logic [4:0]            addr_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];

  logic                  fifo_nempty;
  logic                  accept;
  logic                  acc_nz;
  logic                  cand_valid;
  logic [4:0]            cand_addr;
  logic [DATA_WIDTH-1:0] cand_data;
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign we       = we_q;
  assign wr_data  = wr_data_q;
  assign busy     = (count_q != '0) | (we_q != '0);

  always_comb begin
    fifo_nempty = (count_q != '0);
    accept      = in_valid & in_ready;
    acc_nz      = accept & (in_addr != ZERO_ADDR);

    // FIFO head has priority; an accepted request only bypasses the buffer
    // when the buffer is empty and the register file is not stalled.
    cand_valid  = fifo_nempty | acc_nz;
    cand_addr   = fifo_nempty ? addr_mem_q[rd_ptr_q] : in_addr;
    cand_data   = fifo_nempty ? data_mem_q[rd_ptr_q] : in_data;
    issue       = ~rf_stall & cand_valid;
    pop         = issue & fifo_nempty;
    push        = acc_nz & ~(issue & ~fifo_nempty);

    we_d      = '0;
    wr_data_d = wr_data_q;
    if (issue) begin
      we_d[cand_addr] = 1'b1;
      wr_data_d       = cand_data;
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = in_addr;
      data_mem_d[wr_ptr_q] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      we_q      <= '0;
      wr_data_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      we_q      <= we_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Buffer storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef REGWR_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the last match (tail-most) wins; the write
  // currently on we/wr_data is older than anything still buffered.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (!reset && (fwd_addr != ZERO_ADDR)) begin
      if (we_q[fwd_addr]) begin
        fwd_hit  = 1'b1;
        fwd_data = wr_data_q;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        fwd_idx = rd_ptr_q + PTR_W'(k);
        if ((CNT_W'(k) < count_q) && (addr_mem_q[fwd_idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_demux.sv
module tb_regfile_wr_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [63:0] in_data;
  logic        rf_stall;
  logic [31:0] we;
  logic [63:0] wr_data;
  logic        busy;
`ifdef REGWR_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [63:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wr_demux #(
    .DATA_WIDTH(64),
    .DEPTH     (2),
    .ZERO_REG  (31)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr (in_addr),
    .in_data (in_data),
    .rf_stall(rf_stall),
    .we      (we),
    .wr_data (wr_data),
    .busy    (busy)
`ifdef REGWR_FWD_EN
    ,
    .fwd_addr(fwd_addr),
    .fwd_hit (fwd_hit),
    .fwd_data(fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    rf_stall = 1'b0;
`ifdef REGWR_FWD_EN
    fwd_addr = '0;
`endif
    tick();
    tick();
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_wr_data", wr_data, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    reset = 1'b0;

    // 1: empty buffer bypass, one-cycle latency
    in_valid = 1'b1; in_addr = 5'd5; in_data = 64'hDEAD;
    tick();
    chk("t1_we", 64'(we), 64'h20);
    chk("t1_wr_data", wr_data, 64'hDEAD);
    in_valid = 1'b0;
    tick();
    chk("t1_we_off", 64'(we), 64'h0);
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_wr_data_hold", wr_data, 64'hDEAD);

    // 2: zero-register write swallowed
    in_valid = 1'b1; in_addr = 5'd31; in_data = 64'h1234;
    #1;
    chk("t2_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_we", 64'(we), 64'h0);
      chk("t2_busy", 64'(busy), 64'h0);
      tick();
    end
    chk("t2_wr_data_hold", wr_data, 64'hDEAD);

    // 3: fill under stall, third request refused
    rf_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd1; in_data = 64'h101;
    tick();
    chk("t3_ready_c1", 64'(in_ready), 64'h1);
    in_addr = 5'd2; in_data = 64'h102;
    tick();
    chk("t3_ready_full", 64'(in_ready), 64'h0);
    chk("t3_busy", 64'(busy), 64'h1);
    chk("t3_we_stall", 64'(we), 64'h0);
    in_addr = 5'd3; in_data = 64'h103;
    tick();
    chk("t3_ready_still_full", 64'(in_ready), 64'h0);
    rf_stall = 1'b0; in_valid = 1'b0;
    tick();
    chk("t3_we_a", 64'(we), 64'h2);
    chk("t3_data_a", wr_data, 64'h101);
    tick();
    chk("t3_we_b", 64'(we), 64'h4);
    chk("t3_data_b", wr_data, 64'h102);
    tick();
    chk("t3_we_none", 64'(we), 64'h0);
    chk("t3_busy_idle", 64'(busy), 64'h0);

    // 4: same register twice, issued in acceptance order
    rf_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 64'hAAAA;
    tick();
    in_data = 64'hBBBB;
    tick();
    in_valid = 1'b0; rf_stall = 1'b0;
    tick();
    chk("t4_we_a", 64'(we), 64'h80);
    chk("t4_data_a", wr_data, 64'hAAAA);
    tick();
    chk("t4_we_b", 64'(we), 64'h80);
    chk("t4_data_b", wr_data, 64'hBBBB);
    tick();
    chk("t4_we_none", 64'(we), 64'h0);

    // simultaneous push and pop with a non-empty buffer (no bypass)
    rf_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd10; in_data = 64'h1;
    tick();
    rf_stall = 1'b0;
    in_addr = 5'd11; in_data = 64'h2;
    tick();
    chk("pp_we_head", 64'(we), 64'h400);
    chk("pp_data_head", wr_data, 64'h1);
    chk("pp_busy", 64'(busy), 64'h1);
    in_valid = 1'b0;
    tick();
    chk("pp_we_next", 64'(we), 64'h800);
    chk("pp_data_next", wr_data, 64'h2);
    tick();
    chk("pp_we_none", 64'(we), 64'h0);
    chk("pp_busy_idle", 64'(busy), 64'h0);

    // 5: reset while full discards buffer and the concurrent request
    rf_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd1; in_data = 64'h55;
    tick();
    in_addr = 5'd2;
    tick();
    chk("t5_full", 64'(in_ready), 64'h0);
    reset = 1'b1; rf_stall = 1'b0; in_addr = 5'd6; in_data = 64'h66;
    tick();
    chk("t5_rst_we", 64'(we), 64'h0);
    chk("t5_rst_busy", 64'(busy), 64'h0);
    chk("t5_rst_ready", 64'(in_ready), 64'h1);
    chk("t5_rst_wr_data", wr_data, 64'h0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("t5_we_after", 64'(we), 64'h0);
    chk("t5_busy_after", 64'(busy), 64'h0);
    tick();
    chk("t5_we_after2", 64'(we), 64'h0);

`ifdef REGWR_FWD_EN
    // 6: forwarding returns the youngest matching write
    rf_stall = 1'b1;
    in_valid = 1'b1; in_addr = 5'd9; in_data = 64'h11;
    tick();
    in_data = 64'h22;
    tick();
    in_valid = 1'b0;
    fwd_addr = 5'd9; #1;
    chk("t6_hit", 64'(fwd_hit), 64'h1);
    chk("t6_data", fwd_data, 64'h22);
    fwd_addr = 5'd4; #1;
    chk("t6_miss", 64'(fwd_hit), 64'h0);
    chk("t6_miss_data", fwd_data, 64'h0);
    fwd_addr = 5'd31; #1;
    chk("t6_zero_hit", 64'(fwd_hit), 64'h0);
    fwd_addr = 5'd9;
    rf_stall = 1'b0;
    tick();
    chk("t6_we_a", 64'(we), 64'h200);
    chk("t6_hit_mixed", 64'(fwd_hit), 64'h1);
    chk("t6_data_mixed", fwd_data, 64'h22);
    tick();
    chk("t6_hit_out", 64'(fwd_hit), 64'h1);
    chk("t6_data_out", fwd_data, 64'h22);
    tick();
    chk("t6_hit_idle", 64'(fwd_hit), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wr_demux.md
Name: regfile_wr_demux

Overview:
Write side of the register file: the counterpart to the 32:1 read-mux tree.
- Accepts writeback requests (address and data) over a valid/ready handshake and buffers them in a small FIFO.
- Issues each write to the 32-entry register file as a registered one-hot write-enable vector plus registered data.
- Writes to the zero register are swallowed.

Parameters:
DATA_WIDTH, 64, width of a register value
DEPTH, 2, write-buffer entries (power of two, >=2)
ZERO_REG, 31, hard-wired zero register index; writes to it never issue

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  write request present
in_ready  output  1  buffer can accept this cycle
in_addr  input  5  destination register
in_data  input  DATA_WIDTH  write value
rf_stall  input  1  register file cannot take a new write at the coming edge
we  output  32  one-hot write enable, registered, at most one bit set
wr_data  output  DATA_WIDTH  registered write value, valid when we != 0
busy  output  1  buffer non-empty or we != 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset, sampled at the edge, overrides everything:
  - we=0, wr_data=0, count=0, pointers=0, busy=0.
  - Any request on in_valid that cycle is discarded.
  - A reset mid-burst loses all buffered writes.
- in_ready = (count < DEPTH), where count is the registered count. There is no same-cycle pop credit, so when full in_ready=0 even if a pop occurs.
- Accept: in_valid & in_ready at the edge.
  - in_addr == ZERO_REG: accepted, not enqueued, no we ever.
  - Otherwise the entry is enqueued.
- Issue at each edge (when not in reset):
  - If rf_stall=0 and a candidate exists: we <= 1<<addr, wr_data <= data, pop.
  - Otherwise we <= 0 and wr_data holds its last value.
  - Candidate priority: FIFO head first. If the FIFO is empty, a same-edge accepted non-zero request falls through directly, with no enqueue.
- Latency:
  - Empty buffer, no stall: accept at edge N → we visible in the cycle after edge N (1 cycle).
  - Otherwise strict FIFO order, one write per unstalled edge.
- Simultaneous push and pop: count unchanged, both pointers advance mod DEPTH.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer equality.
- we is asserted for exactly one cycle per issued write. The register file captures we/wr_data on every edge; rf_stall only blocks new issue.
- Ordering: two writes to the same register issue in acceptance order, so the last one wins.
- busy = (count != 0) | (we != 0).

Optional Feature:
Macro REGWR_FWD_EN.
- Defined:
  - Adds input fwd_addr[4:0] and outputs fwd_hit (1) and fwd_data (DATA_WIDTH), all combinational.
  - Search covers the pending writes in the FIFO and the write currently on we/wr_data.
  - fwd_hit=1 when one of them targets fwd_addr, and fwd_data is the youngest matching value. The youngest is the FIFO tail-most entry, otherwise the current output.
  - fwd_addr == ZERO_REG always gives fwd_hit=0, fwd_data=0.
  - During reset, and in the cycle after it, fwd_hit=0.
- Not defined: these ports and the compare logic are absent; the remaining behaviour is identical.

Test Plan:
1. Reset, then in_valid=1, addr=5, data=0xDEAD, rf_stall=0 for one cycle → next cycle we=0x0000_0020, wr_data=0xDEAD; the following cycle we=0, busy=0.
2. addr=31, data=0x1234 accepted → in_ready=1, we stays 0 for 3 cycles, busy stays 0.
3. rf_stall=1, push addr 1, 2, 3 on consecutive cycles → in_ready=0 on the third cycle (count=2). Release rf_stall → we=0x2 then 0x4 on consecutive cycles; the third request is not accepted until re-presented.
4. Push addr 7 data A, then addr 7 data B under stall, then release → we=0x80 with A, then 0x80 with B, in that order.
5. Fill buffer under stall, assert reset for one cycle, release stall → we stays 0, busy=0, in_ready=1.
6. (REGWR_FWD_EN) Stall, push addr 9 data 0x11, then addr 9 data 0x22, fwd_addr=9 → fwd_hit=1, fwd_data=0x22. With fwd_addr=4 → fwd_hit=0.
